// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: owns the fetch PC, issues one outstanding imem request, and buffers {pc,inst} for IF/ID.
// Latency: a response accepted at edge N is visible on inst_valid/inst_out/pc_out from cycle N+1 (registered buffer).
// Backpressure: pc_en_if=0 holds the head entry; a full buffer or an outstanding request blocks new requests.
//
// Ports:
//   clk, rst                      rising-edge clock, asynchronous active-high reset
//   pc_en_if                      IF/ID takes the head entry this cycle (0 = stall)
//   redirect_valid, redirect_pc   taken branch/jump: restart fetch at redirect_pc, flush buffer
//   imem_req_valid/ready/addr     fetch request handshake to instruction memory
//   imem_resp_valid/data          single-cycle response pulse from instruction memory
//   inst_valid, inst_out, pc_out  head entry of the instruction buffer (NOP_INST / 0 when empty)
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // IDLE: nothing outstanding; WAIT: one live request; DROP: outstanding response is stale
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [31:0]     fetch_pc;
  logic [31:0]     fetch_pc_nxt;
  logic [31:0]     req_pc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [31:0]     buf_pc   [FIFO_DEPTH];
  logic [31:0]     buf_inst [FIFO_DEPTH];
  logic            req_fire;
  logic            latch_req;
  logic            push;
  logic            pop;

  // Only request from IDLE with a free slot, so the single in-flight response always fits.
  assign imem_req_valid = !rst && (state == IDLE) && (count < CW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? buf_inst[rd_ptr] : NOP_INST;
  assign pc_out     = inst_valid ? buf_pc[rd_ptr]   : 32'h0000_0000;

  // A redirect flushes the buffer, so it also cancels any pop this cycle.
  assign pop = inst_valid && pc_en_if && !redirect_valid;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    latch_req    = 1'b0;
    push         = 1'b0;
    case (state)
      IDLE: begin
        if (req_fire) begin
          latch_req = 1'b1;
          if (redirect_valid) begin
            // the request just issued belongs to the abandoned path
            state_nxt = DROP;
          end else begin
            state_nxt    = WAIT;
            fetch_pc_nxt = fetch_pc + 32'd4;
          end
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          state_nxt = IDLE;
          push      = !redirect_valid;
        end else if (redirect_valid) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_resp_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) begin
      fetch_pc_nxt = redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (latch_req) begin
        req_pc <= fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (redirect_valid) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage needs no reset: empty entries are masked at the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= req_pc;
      buf_inst[wr_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: randomized imem latency/ready, stalls, redirects and resets.
// Expected delivered stream: consecutive PCs from the last reset/redirect target, each carrying mem_word(pc).
// A monitor checks every cycle against an occupancy/outstanding model and pops expected entries on each IF/ID take.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        pc_en_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;

  if_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_en_if(pc_en_if),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_out(inst_out), .pc_out(pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pops = 0;

  // expected delivered PCs of the current stream
  logic [31:0] exp_q[$];

  // imem model state
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic load_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  // One clock cycle of stimulus: imem response timing, ready, stall, redirect.
  task automatic step(input bit en, input int rdy_pct, input bit redir, input logic [31:0] tgt);
    @(negedge clk);
    imem_resp_valid = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend_addr);
        pend            = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    pc_en_if       = en;
    redirect_valid = redir;
    redirect_pc    = tgt;
    if (redir) load_stream(tgt);
    #1;
    if (imem_req_valid && imem_req_ready) begin
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      pend_cnt  = $urandom_range(lat_max, lat_min);
    end
  endtask

  // Pending imem response survives reset so it arrives late.
  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b0;
    load_stream(RESET_PC);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- monitor / reference model ----------------
  int          occ;
  bit          outstanding;
  bit          stale;
  logic [31:0] exp_req;
  bit          m_pop;
  bit          m_push;
  bit          m_hs;
  logic [31:0] m_pc;

  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst_out", inst_out, NOP);
      chk("rst_pc_out", pc_out, 32'd0);
      chk("rst_req_addr", imem_req_addr, RESET_PC);
      occ         = 0;
      outstanding = 1'b0;
      stale       = 1'b0;
      exp_req     = RESET_PC;
    end else begin
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, occ != 0});
      if (!inst_valid) begin
        chk("empty_inst_out", inst_out, NOP);
        chk("empty_pc_out", pc_out, 32'd0);
      end
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, (!outstanding && occ < DEPTH)});
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);

      m_pop  = inst_valid && pc_en_if && !redirect_valid;
      m_push = imem_resp_valid && outstanding && !stale && !redirect_valid;
      m_hs   = imem_req_valid && imem_req_ready;

      if (m_pop) begin
        m_pc = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("head_pc", pc_out, m_pc);
        chk("head_inst", inst_out, mem_word(m_pc));
        n_pops++;
      end

      if (redirect_valid) begin
        occ     = 0;
        exp_req = redirect_pc;
      end else begin
        occ = occ + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
      end
      if (imem_resp_valid && outstanding) begin
        outstanding = 1'b0;
        stale       = 1'b0;
      end else if (redirect_valid && outstanding) begin
        stale = 1'b1;
      end
      if (m_hs) begin
        outstanding = 1'b1;
        stale       = redirect_valid;
        if (!redirect_valid) exp_req = exp_req + 32'd4;
      end
    end
  end

  // ---------------- stimulus ----------------
  int len;

  initial begin
    rst             = 1'b1;
    pc_en_if        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'd0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    pend            = 1'b0;
    pend_cnt        = 0;
    pend_addr       = 32'd0;
    load_stream(RESET_PC);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // straight-line fetch with a 1-cycle imem
    lat_min = 1; lat_max = 1;
    for (int c = 0; c < 10; c++) step(1, 100, 0, 0);

    // stall until the buffer fills, then drain
    for (int c = 0; c < 8; c++) step(0, 100, 0, 0);
    for (int c = 0; c < 8; c++) step(1, 100, 0, 0);

    // redirect while a request is outstanding -> stale response dropped
    lat_min = 2; lat_max = 2;
    for (int g = 0; g < 10 && !pend; g++) step(1, 100, 0, 0);
    step(1, 100, 1, 32'h0000_0100);
    for (int c = 0; c < 10; c++) step(1, 100, 0, 0);

    // redirect coincident with the response
    lat_min = 1; lat_max = 1;
    for (int g = 0; g < 10 && !pend; g++) step(1, 100, 0, 0);
    step(1, 100, 1, 32'h0000_0200);

    // imem not ready: request held stable
    for (int c = 0; c < 3; c++) step(1, 0, 0, 0);
    for (int c = 0; c < 4; c++) step(1, 100, 0, 0);

    // PC wraps through zero
    step(1, 100, 1, 32'hFFFF_FFF0);
    for (int c = 0; c < 20; c++) step(1, 100, 0, 0);

    // randomized traffic with periodic redirects
    lat_min = 1; lat_max = 3;
    for (int s = 0; s < 40; s++) begin
      len = $urandom_range(40, 10);
      for (int c = 0; c < len; c++) step($urandom_range(99) < 75, 60, 0, 0);
      step(1, 60, 1, $urandom & 32'hFFFF_FFFC);
    end

    // reset while a request is outstanding; its late response must be ignored
    lat_min = 3; lat_max = 3;
    for (int g = 0; g < 20 && !pend; g++) step(1, 100, 0, 0);
    do_reset();
    for (int c = 0; c < 4; c++) step(1, 0, 0, 0);
    lat_min = 1; lat_max = 2;
    for (int c = 0; c < 20; c++) step(1, 100, 0, 0);

    @(negedge clk);
    #3;
    chk("progress", {31'b0, n_pops >= 100}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
